// File: rtl/soc_system_light_irq_svc.sv
// Avalon-MM initiator that services the light-sensor edge-capture PIO:
// programs the IRQ mask, then on each interrupt reads/acks the capture register and samples the level.
module soc_system_light_irq_svc #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] MASK_VAL = 32'h1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq,
    input  logic             enable,
    input  logic             clr_count,
    output logic [1:0]       m_address,
    output logic             m_chipselect,
    output logic             m_write_n,
    output logic [31:0]      m_writedata,
    input  logic [31:0]      m_readdata,
    input  logic             m_waitrequest,
    output logic [CNT_W-1:0] event_count,
    output logic             overflow,
    output logic             last_level,
    output logic             event_pulse,
    output logic             busy
);

    typedef enum logic [2:0] {
        INIT, IDLE, RD_CAP, WT_CAP, CLR, RD_LVL, WT_LVL
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    state_t      state, next_state;
    logic        accept;
    logic        req_cs, req_write_n;
    logic [1:0]  req_address;
    logic [31:0] req_writedata;
    logic        unused_rdata;

    assign accept       = m_chipselect && !m_waitrequest;
    assign busy         = (state != IDLE);
    assign unused_rdata = ^m_readdata[31:1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) state <= INIT;
        else       state <= next_state;
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            INIT:    if (accept) next_state = IDLE;
            IDLE:    if (irq && enable) next_state = RD_CAP;
            RD_CAP:  if (accept) next_state = WT_CAP;
            WT_CAP:  next_state = m_readdata[0] ? CLR : IDLE;
            CLR:     if (accept) next_state = RD_LVL;
            RD_LVL:  if (accept) next_state = WT_LVL;
            WT_LVL:  next_state = IDLE;
            default: next_state = INIT;
        endcase
    end

    // Request fields are decoded from the state being entered and registered,
    // so the bus is glitch-free and holds steady while waitrequest stalls.
    always_comb begin
        req_cs        = 1'b0;
        req_write_n   = 1'b1;
        req_address   = ADDR_DATA;
        req_writedata = 32'h0;
        case (next_state)
            INIT: begin
                req_cs        = 1'b1;
                req_write_n   = 1'b0;
                req_address   = ADDR_MASK;
                req_writedata = MASK_VAL;
            end
            RD_CAP: begin
                req_cs      = 1'b1;
                req_address = ADDR_CAP;
            end
            CLR: begin
                req_cs        = 1'b1;
                req_write_n   = 1'b0;
                req_address   = ADDR_CAP;
                req_writedata = 32'h1;
            end
            RD_LVL: begin
                req_cs      = 1'b1;
                req_address = ADDR_DATA;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= ADDR_DATA;
            m_writedata  <= 32'h0;
        end else begin
            m_chipselect <= req_cs;
            m_write_n    <= req_write_n;
            m_address    <= req_address;
            m_writedata  <= req_writedata;
        end
    end

    // A coinciding clear wins over the increment; the pulse still marks the serviced edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            event_count <= '0;
            overflow    <= 1'b0;
            last_level  <= 1'b0;
            event_pulse <= 1'b0;
        end else begin
            event_pulse <= (state == WT_LVL);
            if (state == WT_LVL) last_level <= m_readdata[0];
            if (clr_count) begin
                event_count <= '0;
                overflow    <= 1'b0;
            end else if (state == WT_LVL) begin
                if (&event_count) overflow    <= 1'b1;
                else              event_count <= event_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_soc_system_light_irq_svc.sv
// Bench for soc_system_light_irq_svc: behavioural edge-capture PIO, bus monitor,
// directed scenario tasks and a randomized run against a saturating-counter model.
module tb_soc_system_light_irq_svc;

    localparam int          CNT_W    = 2;
    localparam logic [31:0] MASK_VAL = 32'h1;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             irq;
    logic             enable = 1'b1;
    logic             clr_count = 1'b0;
    logic [1:0]       m_address;
    logic             m_chipselect;
    logic             m_write_n;
    logic [31:0]      m_writedata;
    logic [31:0]      m_readdata = 32'h0;
    logic             m_waitrequest = 1'b0;
    logic [CNT_W-1:0] event_count;
    logic             overflow;
    logic             last_level;
    logic             event_pulse;
    logic             busy;

    int errors = 0;
    int checks = 0;

    soc_system_light_irq_svc #(.CNT_W(CNT_W), .MASK_VAL(MASK_VAL)) dut (
        .clk(clk), .reset(reset), .irq(irq), .enable(enable), .clr_count(clr_count),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .event_count(event_count), .overflow(overflow), .last_level(last_level),
        .event_pulse(event_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural PIO: data = in_port, mask, bit-clearing edge capture.
    logic in_port = 1'b0, in_prev = 1'b0, pio_mask = 1'b0, pio_cap = 1'b0;
    logic force_irq = 1'b0, pio_lvl = 1'b0;
    wire  acc = m_chipselect && !m_waitrequest;

    assign irq = (pio_cap & pio_mask) | force_irq;

    always @(posedge clk) begin
        if (reset) begin
            pio_mask <= 1'b0;
            pio_cap  <= 1'b0;
            in_prev  <= in_port;
        end else begin
            in_prev <= in_port;
            if (acc && !m_write_n && m_address == 2'd2) pio_mask <= m_writedata[0];
            pio_cap <= (pio_cap & ~(acc && !m_write_n && m_address == 2'd3 && m_writedata[0]))
                       | (in_port & ~in_prev);
        end
        if (!reset && acc && m_write_n) begin
            case (m_address)
                2'd0:    begin m_readdata <= {31'h0, in_port}; pio_lvl <= in_port; end
                2'd2:    m_readdata <= {31'h0, pio_mask};
                2'd3:    m_readdata <= {31'h0, pio_cap};
                default: m_readdata <= 32'h0;
            endcase
        end else begin
            m_readdata <= $urandom;
        end
    end

    // Optional 3-cycle stall on every access.
    bit stall_en = 1'b0;
    int stall_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (stall_en && m_chipselect) begin
            if (stall_cnt < 3) begin m_waitrequest = 1'b1; stall_cnt++; end
            else               begin m_waitrequest = 1'b0; stall_cnt = 0; end
        end else begin
            m_waitrequest = 1'b0;
            stall_cnt     = 0;
        end
    end

    // Bus monitor: accesses accepted at the following rising edge.
    typedef struct packed {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] data;
    } xact_t;
    xact_t log_q[$];
    int    pulse_cnt = 0;

    always @(negedge clk) begin
        if (!reset && acc) log_q.push_back('{m_address, !m_write_n, m_writedata});
        if (event_pulse) pulse_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bit service_seq_ok();
        return log_q.size() == 3
            && log_q[0].addr == 2'd3 && !log_q[0].wr
            && log_q[1].addr == 2'd3 &&  log_q[1].wr && log_q[1].data == 32'h1
            && log_q[2].addr == 2'd0 && !log_q[2].wr;
    endfunction

    task automatic make_edge();
        @(posedge clk); #1 in_port = 1'b0;
        @(posedge clk); #1 in_port = 1'b1;
    endtask

    task automatic wait_irq_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (irq && !busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_pulse(input int max, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            cyc++;
            if (event_pulse) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            errors++;
            $display("FAIL reset_bus: got cs=%b wn=%b a=%0d d=%h expected cs=0 wn=1 a=0 d=0",
                     m_chipselect, m_write_n, m_address, m_writedata);
        end
        checks++;
        if ({event_count, overflow, last_level, event_pulse} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got cnt=%0d ovf=%b lvl=%b pulse=%b expected all 0",
                     event_count, overflow, last_level, event_pulse);
        end
        @(posedge clk); #1 reset = 1'b0;
        log_q.delete();
        @(negedge clk);
        checks++;
        if ({m_chipselect, busy} !== 2'b01) begin
            errors++;
            $display("FAIL init_cycle0: got cs=%b busy=%b expected cs=0 busy=1", m_chipselect, busy);
        end
        @(negedge clk);
        checks++;
        if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b1, 1'b0, 2'd2, MASK_VAL}) begin
            errors++;
            $display("FAIL init_cycle1: got cs=%b wn=%b a=%0d d=%h expected cs=1 wn=0 a=2 d=%h",
                     m_chipselect, m_write_n, m_address, m_writedata, MASK_VAL);
        end
        @(negedge clk);
        checks++;
        if ({busy, m_chipselect} !== 2'b00) begin
            errors++;
            $display("FAIL init_cycle2: got busy=%b cs=%b expected 0 0", busy, m_chipselect);
        end
        checks++;
        if (!(log_q.size() == 1 && log_q[0] == xact_t'({2'd2, 1'b1, MASK_VAL})) || pio_mask !== 1'b1) begin
            errors++;
            $display("FAIL init_write: got %0d accesses, mask=%b expected one write a=2 d=%h",
                     log_q.size(), pio_mask, MASK_VAL);
        end
    endtask

    task automatic test_single_edge();
        int cyc;
        bit ok;
        int p0 = pulse_cnt;
        log_q.delete();
        make_edge();
        wait_irq_idle(ok);
        wait_pulse(20, cyc, ok);
        checks++;
        if (!ok || cyc != 6) begin
            errors++;
            $display("FAIL single_latency: got ok=%b cycles=%0d expected pulse at N+6", ok, cyc);
        end
        checks++;
        if ({event_count, last_level, busy} !== {CNT_W'(1), 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_outputs: got cnt=%0d lvl=%b busy=%b expected cnt=1 lvl=1 busy=0",
                     event_count, last_level, busy);
        end
        @(negedge clk);
        checks++;
        if (service_seq_ok() !== 1'b1 || pulse_cnt - p0 != 1 || irq !== 1'b0) begin
            errors++;
            $display("FAIL single_sequence: got %0d accesses, %0d pulses, irq=%b expected R3 W3(1) R0, 1 pulse, irq=0",
                     log_q.size(), pulse_cnt - p0, irq);
        end
    endtask

    task automatic test_waitrequest();
        int cyc = 0;
        int stalls = 0;
        bit ok;
        bit was_stalled = 1'b0;
        logic [35:0] held = '0;
        int p0 = pulse_cnt;
        stall_en = 1'b1;
        log_q.delete();
        make_edge();
        wait_irq_idle(ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (was_stalled) begin
                checks++;
                if ({m_chipselect, m_write_n, m_address, m_writedata} !== held) begin
                    errors++;
                    $display("FAIL stall_stable: got %h expected held %h",
                             {m_chipselect, m_write_n, m_address, m_writedata}, held);
                end
            end
            was_stalled = m_chipselect && m_waitrequest;
            if (was_stalled) begin
                stalls++;
                held = {m_chipselect, m_write_n, m_address, m_writedata};
            end
            if (event_pulse) begin ok = 1'b1; break; end
        end
        stall_en = 1'b0;
        checks++;
        if (!ok || cyc != 15 || stalls != 9) begin
            errors++;
            $display("FAIL stall_latency: got ok=%b cycles=%0d stalls=%0d expected 15 cycles 9 stalls", ok, cyc, stalls);
        end
        @(negedge clk);
        checks++;
        if (event_count !== CNT_W'(2) || service_seq_ok() !== 1'b1 || pulse_cnt - p0 != 1) begin
            errors++;
            $display("FAIL stall_result: got cnt=%0d accesses=%0d pulses=%0d expected cnt=2, 3 accesses, 1 pulse",
                     event_count, log_q.size(), pulse_cnt - p0);
        end
    endtask

    task automatic test_spurious();
        bit ok = 1'b0;
        int p0 = pulse_cnt;
        log_q.delete();
        @(posedge clk); #1 force_irq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (acc && m_write_n && m_address == 2'd3) begin ok = 1'b1; break; end
        end
        force_irq = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL spurious_start: got no capture read expected one within 10 cycles");
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle: got busy=%b expected 0 after WT_CAP", busy);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (log_q.size() != 1 || event_count !== CNT_W'(2) || pulse_cnt != p0) begin
            errors++;
            $display("FAIL spurious_result: got accesses=%0d cnt=%0d pulses=%0d expected 1, 2, 0",
                     log_q.size(), event_count, pulse_cnt - p0);
        end
    endtask

    task automatic test_enable();
        int cyc;
        bit ok;
        @(posedge clk); #1 enable = 1'b0;
        log_q.delete();
        make_edge();
        repeat (10) @(negedge clk);
        checks++;
        if (log_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL enable_block: got accesses=%0d busy=%b expected 0 0", log_q.size(), busy);
        end
        @(posedge clk); #1 enable = 1'b1;
        wait_pulse(20, cyc, ok);
        checks++;
        if (!ok || event_count !== CNT_W'(3) || service_seq_ok() !== 1'b1) begin
            errors++;
            $display("FAIL enable_release: got ok=%b cnt=%0d accesses=%0d expected pulse, cnt=3, 3 accesses",
                     ok, event_count, log_q.size());
        end
    endtask

    task automatic test_saturate();
        int cyc;
        bit ok;
        @(posedge clk); #1 clr_count = 1'b1;
        @(posedge clk); #1 clr_count = 1'b0;
        @(negedge clk);
        checks++;
        if ({event_count, overflow} !== '0) begin
            errors++;
            $display("FAIL clr_count: got cnt=%0d ovf=%b expected 0 0", event_count, overflow);
        end
        for (int i = 0; i < 5; i++) begin
            make_edge();
            wait_pulse(20, cyc, ok);
            checks++;
            if (!ok || event_count !== CNT_W'((i + 1 > CNT_MAX) ? CNT_MAX : i + 1)
                    || overflow !== (i + 1 > CNT_MAX)) begin
                errors++;
                $display("FAIL saturate_%0d: got ok=%b cnt=%0d ovf=%b expected cnt=%0d ovf=%0d", i + 1, ok,
                         event_count, overflow, (i + 1 > CNT_MAX) ? CNT_MAX : i + 1, i + 1 > CNT_MAX);
            end
        end
        make_edge();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc && m_write_n && m_address == 2'd0) begin ok = 1'b1; break; end
        end
        @(negedge clk) clr_count = 1'b1;
        @(negedge clk);
        checks++;
        if (!ok || {event_pulse, event_count, overflow} !== {1'b1, CNT_W'(0), 1'b0}) begin
            errors++;
            $display("FAIL clr_wins: got ok=%b pulse=%b cnt=%0d ovf=%b expected pulse=1 cnt=0 ovf=0",
                     ok, event_pulse, event_count, overflow);
        end
        clr_count = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        stall_en = 1'b1;
        make_edge();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m_chipselect && m_waitrequest && !m_write_n && m_address == 2'd3) begin ok = 1'b1; break; end
        end
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        stall_en = 1'b0;
        checks++;
        if (!ok || {m_chipselect, m_write_n, m_address, m_writedata} !== {1'b0, 1'b1, 2'd0, 32'h0}
                || {event_count, overflow, last_level, event_pulse} !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got ok=%b cs=%b wn=%b a=%0d cnt=%0d lvl=%b busy=%b expected reset values",
                     ok, m_chipselect, m_write_n, m_address, event_count, last_level, busy);
        end
        @(posedge clk); #1 reset = 1'b0;
        log_q.delete();
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (log_q.size() > 0) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || log_q[0] != xact_t'({2'd2, 1'b1, MASK_VAL})) begin
            errors++;
            $display("FAIL reset_remask: got ok=%b first access %h expected mask write with enable low", ok,
                     ok ? log_q[0] : xact_t'(0));
        end
        repeat (5) @(negedge clk);
        checks++;
        if (log_q.size() != 1 || busy !== 1'b0 || pio_mask !== 1'b1) begin
            errors++;
            $display("FAIL reset_settle: got accesses=%0d busy=%b mask=%b expected 1 0 1", log_q.size(), busy, pio_mask);
        end
        @(posedge clk); #1 enable = 1'b1;
    endtask

    task automatic test_random();
        int  mdl_count = 0;
        bit  mdl_ovf = 1'b0;
        bit  mdl_level = 1'b0;
        int  rises = 0, serviced = 0;
        int  r3 = 0, w3 = 0, r0 = 0, other = 0;
        bit  clr_s, ok;
        log_q.delete();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            clr_s = clr_count;
            #1;
            clr_count = ($urandom_range(0, 49) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) stall_en = !stall_en;
            if ($urandom_range(0, 5) == 0) begin
                if (!in_port) rises++;
                in_port = !in_port;
            end
            @(negedge clk);
            if (event_pulse) begin serviced++; mdl_level = pio_lvl; end
            if (clr_s) begin
                mdl_count = 0;
                mdl_ovf   = 1'b0;
            end else if (event_pulse) begin
                if (mdl_count == CNT_MAX) mdl_ovf = 1'b1;
                else                      mdl_count++;
            end
            checks++;
            if ({event_count, overflow, last_level} !== {CNT_W'(mdl_count), mdl_ovf, mdl_level}) begin
                errors++;
                $display("FAIL random_cycle%0d: got cnt=%0d ovf=%b lvl=%b expected cnt=%0d ovf=%b lvl=%b",
                         i, event_count, overflow, last_level, mdl_count, mdl_ovf, mdl_level);
            end
        end
        @(posedge clk); #1;
        clr_count = 1'b0;
        enable    = 1'b1;
        stall_en  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (event_pulse) serviced++;
            if (!busy && !irq && !event_pulse) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL random_drain: got busy=%b irq=%b expected idle with irq low", busy, irq);
        end
        foreach (log_q[k]) begin
            if (log_q[k].addr == 2'd3 && !log_q[k].wr)                             r3++;
            else if (log_q[k].addr == 2'd3 && log_q[k].wr && log_q[k].data == 32'h1) w3++;
            else if (log_q[k].addr == 2'd0 && !log_q[k].wr)                        r0++;
            else                                                                   other++;
        end
        checks++;
        if (r3 != serviced || w3 != serviced || r0 != serviced || other != 0 || serviced > rises || serviced == 0) begin
            errors++;
            $display("FAIL random_bus: got r3=%0d w3=%0d r0=%0d other=%0d serviced=%0d rises=%0d expected equal counts, no others",
                     r3, w3, r0, other, serviced, rises);
        end
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_waitrequest();
        test_spurious();
        test_enable();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/soc_system_light_irq_svc.md
# soc_system_light_irq_svc

Avalon-MM initiator that services the light-sensor edge-capture PIO without CPU involvement. After reset it writes the PIO interrupt mask. On each `irq` it reads the edge-capture register, acknowledges it by writing that register, reads the live input level, and then updates a saturating event counter. It sits in the FPGA fabric of `soc_system`, directly on the PIO's slave port, and exposes event count and level to fabric logic.

## Interface
- `CNT_W`, 16: width of `event_count`.
- `MASK_VAL`, 32'h1: value written to the PIO mask register at init.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `irq`  in  1  PIO interrupt, level, active-high.
- `enable`  in  1  permits starting a new service sequence.
- `clr_count`  in  1  synchronous clear of `event_count` and `overflow`.
- `m_address`  out  2  PIO register select (0 data, 2 mask, 3 edge capture).
- `m_chipselect`  out  1  access request.
- `m_write_n`  out  1  0 = write, 1 = read.
- `m_writedata`  out  32  write data.
- `m_readdata`  in  32  read data, valid exactly one cycle after read acceptance.
- `m_waitrequest`  in  1  stall; tie 0 for the PIO.
- `event_count`  out  CNT_W  serviced edges, saturating.
- `overflow`  out  1  sticky; set when an increment is attempted at max count.
- `last_level`  out  1  data bit 0 from the most recent level read.
- `event_pulse`  out  1  one-cycle strobe per serviced edge.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: INIT, IDLE, RD_CAP, WT_CAP, CLR, RD_LVL, WT_LVL.
- An access is accepted in a cycle with `m_chipselect`=1 and `m_waitrequest`=0. Address, `m_write_n` and `m_writedata` are held stable until acceptance. `m_chipselect`=0 in IDLE, WT_CAP and WT_LVL.
- INIT: write `MASK_VAL` to address 2. On acceptance, go to IDLE.
- IDLE: if `irq` && `enable`, go to RD_CAP. Otherwise stay.
- RD_CAP: read address 3. On acceptance, go to WT_CAP.
- WT_CAP: sample `m_readdata`.
  - Bit 0 = 1: go to CLR.
  - Bit 0 = 0 (spurious): go to IDLE with no count change.
- CLR: write 32'h1 to address 3. On acceptance, go to RD_LVL.
- RD_LVL: read address 0. On acceptance, go to WT_LVL.
- WT_LVL: on the next edge:
  - `last_level` <= `m_readdata[0]`.
  - `event_count` increments; at all-ones it holds and `overflow` <= 1.
  - `event_pulse` <= 1 for one cycle.
  - State goes to IDLE.
- `clr_count` zeroes `event_count` and `overflow` in any state. If it coincides with a WT_LVL increment, the clear wins and `event_pulse` still fires.
- `enable` low does not abort a sequence in progress. It blocks only the IDLE->RD_CAP transition. INIT runs regardless of `enable`.
- Reset values:
  - state INIT
  - `event_count` 0, `overflow` 0, `last_level` 0, `event_pulse` 0
  - `m_chipselect` 0, `m_write_n` 1, `m_address` 0, `m_writedata` 0
- Reset asserted mid-sequence: everything returns to reset values and the mask is rewritten. A partially issued access is abandoned.

## Timing
- First INIT write is presented the cycle after `reset` deasserts.
- With `m_waitrequest`=0, `irq` seen high in IDLE at cycle N gives:
  - RD_CAP at N+1
  - WT_CAP at N+2
  - CLR at N+3
  - RD_LVL at N+4
  - WT_LVL at N+5
  - `event_pulse` and new count visible at N+6, back in IDLE.
- Each cycle of `m_waitrequest`=1 adds one cycle to the affected state.
- The PIO drops `irq` the cycle after the CLR write is accepted. By the time the block returns to IDLE, `irq` reflects only edges captured after the clear, so there is no double count.
- An edge arriving during the sequence, after CLR acceptance, re-asserts `irq` and is serviced on return to IDLE.

## Test plan
- Reset release with the PIO model attached -> one write, address 2 data 32'h1, at cycle 1; `busy` drops at cycle 2; all outputs at reset values.
- Single rising edge on PIO `in_port`, level held 1 -> exact sequence: read 3, write 3 (data 1), read 0; `event_count`=1, `last_level`=1, one `event_pulse`, `irq` low afterwards.
- `m_waitrequest` high 3 cycles on each access -> request fields stable throughout; the sequence stretches by 9 cycles; count still 1.
- Forced `irq` with capture register reading 0 -> return to IDLE after WT_CAP; no write to address 3; count unchanged; no pulse.
- `CNT_W`=2, 5 edges -> count 3, `overflow`=1. Then `clr_count` coinciding with a sixth increment -> count 0, `overflow` 0, pulse seen.
- `reset` asserted in CLR -> outputs at reset values next cycle, mask rewritten. `enable`=0 with `irq` high -> no access issued until `enable` rises.
